// File: rtl/fifo_ctrl.sv
// Streaming FIFO controller around a single-port RAM: write and read requests share
// one port and are arbitrated alternately; read data lands in a registered output stage.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 24,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       ram_ce,
  output logic                       ram_we,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_d,
  input  logic [DATA_WIDTH-1:0]      ram_q,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {GNT_READ = 1'b0, GNT_WRITE = 1'b1} gnt_e;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  gnt_e                  last_q, last_d;

  logic full_c, empty_c, wr_req, rd_req, wr_gnt, rd_gnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full_c  = (count_q == CW'(DEPTH));
    empty_c = (count_q == '0);
    wr_req  = s_valid && !full_c;
    rd_req  = !empty_c && (!m_valid_q || m_ready);
    wr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    // A cycle that clears state never touches the RAM.
    if (!rst && !flush) begin
      if (wr_req && rd_req) begin
        wr_gnt = (last_q == GNT_READ);
        rd_gnt = (last_q == GNT_WRITE);
      end else begin
        wr_gnt = wr_req;
        rd_gnt = rd_req;
      end
    end
  end

  always_comb begin
    s_ready  = wr_gnt;
    ram_ce   = wr_gnt || rd_gnt;
    ram_we   = wr_gnt;
    ram_addr = '0;
    ram_d    = '0;
    if (wr_gnt) begin
      ram_addr = ADDR_WIDTH'(wr_ptr_q);
      ram_d    = s_data;
    end else if (rd_gnt) begin
      ram_addr = ADDR_WIDTH'(rd_ptr_q);
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    last_d    = last_q;
    if (wr_gnt) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d  = count_q + 1'b1;
      last_d   = GNT_WRITE;
    end
    // A read in the same cycle as a downstream accept refills without a bubble.
    if (rd_gnt) begin
      rd_ptr_d  = ptr_inc(rd_ptr_q);
      count_d   = count_q - 1'b1;
      m_data_d  = ram_q;
      m_valid_d = 1'b1;
      last_d    = GNT_READ;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      last_q    <= GNT_READ;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      last_q    <= last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign count   = count_q;
  assign full    = full_c && !rst;
  assign empty   = empty_c || rst;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: behavioural single-port RAM, scoreboard of accepted words,
// pointer tracking on every grant and directed phases for reset/fill/backpressure/flush/stream.
module tb_fifo_ctrl;
  localparam int DW = 24;
  localparam int DEPTH = 24;
  localparam int AW = 18;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst, flush, s_valid, s_ready, m_valid, m_ready;
  logic          ram_ce, ram_we, full, empty;
  logic [DW-1:0] s_data, m_data, ram_d, ram_q;
  logic [AW-1:0] ram_addr;
  logic [CW-1:0] count;

  int vectors = 0;
  int miscompares = 0;
  int exp_wp = 0;
  int exp_rp = 0;
  int n_out = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] mem[DEPTH];

  always #5 clk = ~clk;

  fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q),
    .count(count), .full(full), .empty(empty)
  );

  always @(posedge clk)
    if (ram_ce && ram_we && ram_addr < AW'(DEPTH)) mem[ram_addr[4:0]] <= ram_d;
  assign ram_q = (ram_ce && !ram_we && ram_addr < AW'(DEPTH)) ? mem[ram_addr[4:0]] : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pointer tracking, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
      exp_wp = 0;
      exp_rp = 0;
    end else begin
      if (ram_ce && ram_we) begin
        chk("wr_addr", 32'(ram_addr), exp_wp);
        chk("wr_data", 32'(ram_d), 32'(s_data));
        exp_wp = (exp_wp + 1) % DEPTH;
      end
      if (ram_ce && !ram_we) begin
        chk("rd_addr", 32'(ram_addr), exp_rp);
        exp_rp = (exp_rp + 1) % DEPTH;
      end
      if (m_valid && m_ready) begin
        chk("out_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("out_data", 32'(m_data), 32'(sb.pop_front()));
        n_out++;
      end
      if (s_valid && s_ready) sb.push_back(s_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("push_accept", 32'(ok), 1);
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nxt, g;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b1; s_data = 24'hABCDEF; m_ready = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_ram_ce", 32'(ram_ce), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_d", 32'(ram_d), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    tick(); tick();
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_m_valid", 32'(m_valid), 0);
      chk("idle_s_ready", 32'(s_ready), 0);
      chk("idle_empty", 32'(empty), 1);
      chk("idle_count", 32'(count), 0);
      chk("idle_ram_ce", 32'(ram_ce), 0);
    end
    chk("idle_m_data", 32'(m_data), 0);
    tick();

    // First words with downstream stalled: one moves into the output register.
    push(24'h000001); push(24'h000002); push(24'h000003);
    repeat (3) tick();
    @(negedge clk);
    chk("p2_m_valid", 32'(m_valid), 1);
    chk("p2_m_data", 32'(m_data), 1);
    chk("p2_count", 32'(count), 2);
    chk("p2_ram_ce", 32'(ram_ce), 0);
    tick();

    // Fill to capacity.
    for (int d = 4; d <= 25; d++) push(DW'(d));
    s_valid = 1'b1; s_data = 24'h000077;
    @(negedge clk);
    chk("full_flag", 32'(full), 1);
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_count", 32'(count), DEPTH);
    chk("full_empty", 32'(empty), 0);
    chk("full_ram_ce", 32'(ram_ce), 0);
    chk("full_m_data", 32'(m_data), 1);
    tick();
    s_valid = 1'b0;

    // Backpressure 1,0,0,1.
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp0_m_valid", 32'(m_valid), 1);
    tick();
    m_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(m_valid), 1);
      chk("bp_hold_data", 32'(m_data), 2);
      tick();
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp3_m_data", 32'(m_data), 2);
    tick();
    for (int i = 0; i < 100 && !(empty && !m_valid); i++) tick();
    @(negedge clk);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_m_valid", 32'(m_valid), 0);
    chk("drain_count", 32'(count), 0);
    chk("drain_sb", 32'(sb.size()), 0);
    tick();

    // Flush with count=5 and a word in the output register.
    m_ready = 1'b0;
    for (int d = 0; d < 6; d++) push(DW'(24'h500 + d));
    @(negedge clk);
    chk("pre_flush_count", 32'(count), 5);
    chk("pre_flush_m_valid", 32'(m_valid), 1);
    tick();
    flush = 1'b1; s_valid = 1'b1; s_data = 24'h0000EE; m_ready = 1'b1;
    @(negedge clk);
    chk("flush_ram_ce", 32'(ram_ce), 0);
    chk("flush_s_ready", 32'(s_ready), 0);
    tick();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    chk("post_flush_count", 32'(count), 0);
    chk("post_flush_m_valid", 32'(m_valid), 0);
    chk("post_flush_empty", 32'(empty), 1);
    tick();
    s_valid = 1'b1; s_data = 24'h00005A;
    @(negedge clk);
    chk("post_flush_wr_we", 32'(ram_we), 1);
    chk("post_flush_wr_addr", 32'(ram_addr), 0);
    tick();
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (4) tick();

    // Sustained contention: strict W,R alternation and in-order delivery.
    n_out = 0; nxt = 0;
    s_valid = 1'b1; s_data = '0;
    for (int cyc = 0; cyc < 400 && nxt < 100; cyc++) begin
      @(negedge clk);
      g = ram_ce ? (ram_we ? 1 : 2) : 0;
      chk("stream_grant", g, (cyc % 2 == 0) ? 1 : 2);
      if (s_ready) nxt++;
      tick();
      s_data = DW'(nxt);
      if (nxt == 100) s_valid = 1'b0;
    end
    chk("stream_all_in", nxt, 100);
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    @(negedge clk);
    chk("stream_n_out", n_out, 100);
    chk("stream_sb_empty", 32'(sb.size()), 0);
    chk("stream_end_empty", 32'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Controller that turns the single-port `fifo` RAM (one access per cycle, combinational read when ce=1/we=0) into a streaming FIFO.
- Accepts a valid/ready input stream and owns the RAM's ce/we/addr/d pins.
- Arbitrates the single port between write and read requests.
- Presents a registered valid/ready output stream; sits between the DMA stream side and the editing accelerator datapath.

Parameters:
- DATA_WIDTH, 24, word width; must match the RAM.
- DEPTH, 24, number of RAM entries; any value >= 2, not necessarily a power of two.
- ADDR_WIDTH, 18, width of the RAM address port; upper bits beyond the pointer width are driven 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous clear of FIFO contents (same effect as rst on controller state)
- s_valid  in  1  input word valid
- s_ready  out  1  input accepted this cycle (write granted)
- s_data  in  DATA_WIDTH  input word
- m_valid  out  1  output register holds a word
- m_ready  in  1  downstream accepts m_data
- m_data  out  DATA_WIDTH  output word (registered)
- ram_ce  out  1  RAM chip enable
- ram_we  out  1  RAM write enable (1 write, 0 read)
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_d  out  DATA_WIDTH  RAM write data
- ram_q  in  DATA_WIDTH  RAM read data (combinational, valid same cycle)
- count  out  $clog2(DEPTH+1)  words stored in RAM (excludes output register)
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset/flush values: wr_ptr=0, rd_ptr=0, count=0, m_valid=0, m_data=0, last_grant=READ.
  - Outputs during rst: s_ready=0, ram_ce=0, ram_we=0, ram_addr=0, ram_d=0, empty=1, full=0.
  - rst has priority over flush; flush has priority over any grant in that cycle (no RAM access, s_ready=0).
- Requests, evaluated combinationally each cycle:
  - wr_req = s_valid && !full
  - rd_req = !empty && (!m_valid || m_ready)
- Arbiter (1-bit last_grant state):
  - Only one request present: grant it.
  - Both present: grant the opposite of last_grant.
  - last_grant updates only on a grant.
  - The first conflict after reset goes to WRITE.
- Write grant:
  - s_ready=1, ram_ce=1, ram_we=1, ram_addr=wr_ptr, ram_d=s_data.
  - wr_ptr advances; it wraps DEPTH-1 -> 0.
- Read grant:
  - ram_ce=1, ram_we=0, ram_addr=rd_ptr.
  - At the clock edge: m_data <= ram_q, m_valid <= 1, rd_ptr advances with the same wrap rule.
- No grant: ram_ce=0, ram_we=0, ram_addr=0, ram_d=0, s_ready=0.
- Output stream:
  - If m_valid && m_ready and there is no read grant: m_valid <= 0, m_data holds.
  - If there is a read grant in the same cycle as m_ready, m_data is replaced with no bubble.
  - m_data and m_valid are stable while m_valid && !m_ready.
- count: +1 on write grant, -1 on read grant. The two never occur in the same cycle, so there is no simultaneous update.
- Latency: a word written in cycle N is read no earlier than cycle N+1 and appears on m_valid in cycle N+2 (min 2 cycles through).
- Boundaries:
  - full: s_ready=0 regardless of s_valid.
  - empty with m_valid=0: m_valid stays 0.
  - s_ready may depend on s_valid and m_ready; m_valid never depends on m_ready combinationally.
- Throughput: under sustained contention, writes and reads alternate (0.5 word/cycle each).

Test Plan:
- Reset then idle -> m_valid=0, s_ready=0, empty=1, count=0, ram_ce=0 for 5 cycles.
- Write 0x000001..0x000003 with m_ready=0 -> 3 write grants, count=3. The first read grant then fills the output register: m_valid=1, m_data=0x000001, count=2. No further reads while m_ready=0.
- Fill to DEPTH=24 with m_ready=0 -> after 24 accepted words plus 1 word moved to the output register, full=1 and s_ready=0 even with s_valid=1.
- Continuous s_valid and m_ready=1, stream 0..99 -> grants alternate W,R,W,R after the first conflict (first conflict = W). Output sequence is 0..99 in order; ram_addr wraps 23 -> 0 with no loss.
- Backpressure: m_ready toggles 1,0,0,1 while m_valid=1 -> m_data unchanged during m_ready=0 cycles; no word skipped or duplicated.
- flush with count=5 and m_valid=1 -> next cycle count=0, m_valid=0, empty=1, pointers=0; ram_ce=0 in the flush cycle.
